sys_bridge: RTL and testbench

- Processor-side system bridge sitting directly downstream of the CPU core's memory stage.
- Consumes PrAddr/PrWD/IOWrite, returns PrRD combinationally, and drives the core's HWInt[7:2].
- Hosts two programmable countdown timers (T0, T1), a 32-bit output register and a 32-bit input port.
- Timer interrupts feed HWInt[2] and HWInt[3].

---
 rtl/bridge_pkg.sv | 29 ++
 rtl/timer_dev.sv | 80 ++++++++
 rtl/sys_bridge.sv | 97 +++++++++
 tb/tb_sys_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the processor-side system bridge: register map,
// CTRL field positions, timer modes and the timer state encoding.
package bridge_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } tmr_state_e;

    localparam logic [31:0] T0_BASE_DEF  = 32'h0000_7F00;
    localparam logic [31:0] T1_BASE_DEF  = 32'h0000_7F10;
    localparam logic [31:0] OUT_ADDR_DEF = 32'h0000_7F20;
    localparam logic [31:0] IN_ADDR_DEF  = 32'h0000_7F24;

endpackage

// File: rtl/timer_dev.sv
// One programmable countdown timer: CTRL/PRESET/COUNT registers, the
// IDLE/LOAD/CNT/INT sequencer and the raw (unmasked) interrupt flag.
module timer_dev
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_we_i,
    input  logic        preset_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] preset_o,
    output logic [31:0] count_o,
    output logic        irq_o
);

    tmr_state_e  state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_q;
    logic        en;
    logic        auto_reload;

    assign en          = ctrl_q[CTRL_EN];
    assign auto_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'b0;
            preset_q <= 32'b0;
            count_q  <= 32'b0;
            irq_q    <= 1'b0;
        end else begin
            if (preset_we_i)
                preset_q <= wdata_i;
            // A CTRL write overrides whatever the sequencer would do this edge;
            // COUNT is left where it was.
            if (ctrl_we_i) begin
                ctrl_q  <= wdata_i[3:0];
                state_q <= ST_IDLE;
                irq_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (en) state_q <= ST_LOAD;
                    ST_LOAD: begin
                        count_q <= preset_q;
                        state_q <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!en)
                            state_q <= ST_IDLE;
                        else if (count_q > 32'd1)
                            count_q <= count_q - 32'd1;
                        else begin
                            count_q <= 32'd0;
                            state_q <= ST_INT;
                            irq_q   <= 1'b1;
                        end
                    end
                    ST_INT: begin
                        state_q <= ST_IDLE;
                        if (auto_reload)
                            irq_q <= 1'b0;
                        else
                            ctrl_q[CTRL_EN] <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ctrl_o   = {28'b0, ctrl_q};
    assign preset_o = preset_q;
    assign count_o  = count_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/sys_bridge.sv
// System bridge below the CPU memory stage: address decode, combinational
// read mux, output register and interrupt line assembly for two timers.
module sys_bridge
    import bridge_pkg::*;
#(
    parameter logic [31:0] T0_BASE  = T0_BASE_DEF,
    parameter logic [31:0] T1_BASE  = T1_BASE_DEF,
    parameter logic [31:0] OUT_ADDR = OUT_ADDR_DEF,
    parameter logic [31:0] IN_ADDR  = IN_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        IOWrite,
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt,
    input  logic [31:0] dev_in,
    output logic [31:0] dev_out
);

    logic [31:0] addr;
    logic [31:0] t0_off, t1_off;
    logic        t0_hit, t1_hit;
    logic [1:0]  t0_reg, t1_reg;
    logic [31:0] t0_ctrl, t0_preset, t0_count;
    logic [31:0] t1_ctrl, t1_preset, t1_count;
    logic        t0_irq, t1_irq;
    logic [31:0] dev_out_q;

    // Each timer spans three words from its base; offset 3 is a hole.
    assign addr   = {PrAddr, 2'b00};
    assign t0_off = addr - T0_BASE;
    assign t1_off = addr - T1_BASE;
    assign t0_hit = (t0_off < 32'd12);
    assign t1_hit = (t1_off < 32'd12);
    assign t0_reg = t0_off[3:2];
    assign t1_reg = t1_off[3:2];

    timer_dev u_t0 (
        .clk         (clk),
        .rst         (rst),
        .ctrl_we_i   (IOWrite && t0_hit && t0_reg == OFF_CTRL),
        .preset_we_i (IOWrite && t0_hit && t0_reg == OFF_PRESET),
        .wdata_i     (PrWD),
        .ctrl_o      (t0_ctrl),
        .preset_o    (t0_preset),
        .count_o     (t0_count),
        .irq_o       (t0_irq)
    );

    timer_dev u_t1 (
        .clk         (clk),
        .rst         (rst),
        .ctrl_we_i   (IOWrite && t1_hit && t1_reg == OFF_CTRL),
        .preset_we_i (IOWrite && t1_hit && t1_reg == OFF_PRESET),
        .wdata_i     (PrWD),
        .ctrl_o      (t1_ctrl),
        .preset_o    (t1_preset),
        .count_o     (t1_count),
        .irq_o       (t1_irq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dev_out_q <= 32'b0;
        else if (IOWrite && addr == OUT_ADDR)
            dev_out_q <= PrWD;
    end

    always_comb begin
        PrRD = 32'h0;
        if (t0_hit) begin
            case (t0_reg)
                OFF_CTRL:   PrRD = t0_ctrl;
                OFF_PRESET: PrRD = t0_preset;
                OFF_COUNT:  PrRD = t0_count;
                default:    PrRD = 32'h0;
            endcase
        end else if (t1_hit) begin
            case (t1_reg)
                OFF_CTRL:   PrRD = t1_ctrl;
                OFF_PRESET: PrRD = t1_preset;
                OFF_COUNT:  PrRD = t1_count;
                default:    PrRD = 32'h0;
            endcase
        end else if (addr == OUT_ADDR) begin
            PrRD = dev_out_q;
        end else if (addr == IN_ADDR) begin
            PrRD = dev_in;
        end
    end

    assign dev_out = dev_out_q;
    assign HWInt   = {4'b0, t1_irq & t1_ctrl[CTRL_IM], t0_irq & t0_ctrl[CTRL_IM]};

endmodule

// File: tb/tb_sys_bridge.sv
// Directed and randomized checks of sys_bridge against an arithmetic model of
// timer interrupt timing (expiry edge, reload period, one-shot latching).
module tb_sys_bridge;

    localparam logic [31:0] T0   = 32'h0000_7F00;
    localparam logic [31:0] T1   = 32'h0000_7F10;
    localparam logic [31:0] OUTA = 32'h0000_7F20;
    localparam logic [31:0] INA  = 32'h0000_7F24;
    localparam logic [31:0] HOLE = 32'h0000_7F30;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PrAddr;
    logic [31:0] PrWD;
    logic        IOWrite;
    logic [31:0] PrRD;
    logic [7:2]  HWInt;
    logic [31:0] dev_in;
    logic [31:0] dev_out;

    int n_chk  = 0;
    int n_pass = 0;
    int ed     = 0;

    sys_bridge dut (
        .clk     (clk),
        .rst     (rst),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .IOWrite (IOWrite),
        .PrRD    (PrRD),
        .HWInt   (HWInt),
        .dev_in  (dev_in),
        .dev_out (dev_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ed++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        PrAddr  = a[31:2];
        PrWD    = d;
        IOWrite = 1'b1;
        tick();
        IOWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        PrAddr = a[31:2];
        #1;
        d = PrRD;
    endtask

    function automatic logic [31:0] hw();
        return 32'(HWInt);
    endfunction

    // Interrupt flag k edges after the CTRL write that started the timer.
    function automatic logic exp_irq(int k, int p, logic [1:0] mode);
        int n;
        n = (p == 0) ? 1 : p;
        if (k < n + 2) return 1'b0;
        if (mode == 2'b01) return ((k - n - 2) % (n + 3)) == 0;
        return 1'b1;
    endfunction

    initial begin
        logic [31:0] rv;
        int          e0, e1, p0, p1, n0, n1;
        logic [1:0]  m0, m1;
        logic        im0, im1;
        logic [3:0]  c0, c1;
        logic [31:0] exp_hw;

        rst = 1'b0; IOWrite = 1'b0; PrAddr = '0; PrWD = '0; dev_in = '0;
        tick(); tick();
        chk("reset_hwint", hw(), 32'h0);
        chk("reset_devout", dev_out, 32'h0);
        rd(T0, rv); chk("reset_t0ctrl", rv, 32'h0);
        rst = 1'b1;
        tick();

        // bus decode
        wr(OUTA, 32'hDEAD_BEEF);
        chk("out_reg", dev_out, 32'hDEAD_BEEF);
        rd(OUTA, rv); chk("out_read", rv, 32'hDEAD_BEEF);
        dev_in = 32'h1234;
        rd(INA, rv); chk("in_read", rv, 32'h1234);
        wr(T0 + 8, 32'h55);
        rd(T0 + 8, rv); chk("count_ro", rv, 32'h0);
        wr(HOLE, 32'h1111);
        rd(HOLE, rv); chk("hole_read", rv, 32'h0);
        chk("hole_no_out", dev_out, 32'hDEAD_BEEF);
        wr(INA, 32'h9999);
        rd(INA, rv); chk("in_ro", rv, 32'h1234);
        rd(T0 + 4, rv); chk("stray_t0preset", rv, 32'h0);
        rd(T1, rv); chk("stray_t1ctrl", rv, 32'h0);

        // one-shot T0
        wr(T0 + 4, 32'd3);
        wr(T0, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("oneshot_e%0d", k), hw(), (k >= 5) ? 32'h1 : 32'h0);
        end
        rd(T0, rv); chk("oneshot_en_clr", rv, 32'h8);
        rd(T0 + 8, rv); chk("oneshot_count", rv, 32'h0);
        wr(T0, 32'h0);
        chk("oneshot_ack", hw(), 32'h0);

        // auto-reload T1
        wr(T1 + 4, 32'd3);
        wr(T1, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk($sformatf("auto_e%0d", k), hw(), (k == 5 || k == 11 || k == 17) ? 32'h2 : 32'h0);
        end
        wr(T1, 32'h0);

        // masked
        wr(T0 + 4, 32'd3);
        wr(T0, 32'h1);
        repeat (6) tick();
        rd(T0 + 8, rv); chk("masked_count", rv, 32'h0);
        chk("masked_hwint", hw(), 32'h0);
        wr(T0, 32'h0);

        // disable freezes COUNT
        wr(T0 + 4, 32'd10);
        wr(T0, 32'h1);
        repeat (6) tick();
        rd(T0 + 8, rv); chk("freeze_pre", rv, 32'd6);
        wr(T0, 32'h0);
        repeat (3) tick();
        rd(T0 + 8, rv); chk("freeze_post", rv, 32'd6);

        // collision with the expiry edge
        wr(T0 + 4, 32'd3);
        wr(T0, 32'h9);
        repeat (4) tick();
        wr(T0, 32'h8);
        chk("coll_hwint", hw(), 32'h0);
        rd(T0, rv); chk("coll_ctrl", rv, 32'h8);
        repeat (3) tick();
        chk("coll_hwint_late", hw(), 32'h0);
        wr(T0, 32'h9);
        repeat (5) tick();
        chk("coll_restart", hw(), 32'h1);
        wr(T0, 32'h0);

        // simultaneous expiry
        wr(T1 + 4, 32'd4);
        wr(T0 + 4, 32'd3);
        wr(T1, 32'h9);
        wr(T0, 32'h9);
        repeat (4) tick();
        chk("simul_pre", hw(), 32'h0);
        tick();
        chk("simul_both", hw(), 32'h3);
        wr(T0, 32'h0);
        wr(T1, 32'h0);

        // randomized timers against the arithmetic model
        for (int it = 0; it < 8; it++) begin
            p0 = $urandom_range(0, 7); p1 = $urandom_range(0, 7);
            m0 = 2'($urandom_range(0, 3)); m1 = 2'($urandom_range(0, 3));
            im0 = 1'($urandom_range(0, 1)); im1 = 1'($urandom_range(0, 1));
            c0 = {im0, m0, 1'b1}; c1 = {im1, m1, 1'b1};
            n0 = (p0 == 0) ? 1 : p0; n1 = (p1 == 0) ? 1 : p1;
            wr(T0, 32'h0);
            wr(T1, 32'h0);
            wr(T0 + 4, 32'(p0));
            wr(T1 + 4, 32'(p1));
            wr(T0, 32'(c0)); e0 = ed;
            wr(T1, 32'(c1)); e1 = ed;
            for (int k = 0; k < 22; k++) begin
                exp_hw = {30'b0, im1 & exp_irq(ed - e1, p1, m1), im0 & exp_irq(ed - e0, p0, m0)};
                chk($sformatf("rnd%0d_c%0d", it, k), hw(), exp_hw);
                tick();
            end
            rd(T0, rv);
            chk($sformatf("rnd%0d_ctrl0", it), rv,
                (m0 != 2'b01 && ed - e0 >= n0 + 2) ? 32'(c0 & 4'hE) : 32'(c0));
            rd(T1, rv);
            chk($sformatf("rnd%0d_ctrl1", it), rv,
                (m1 != 2'b01 && ed - e1 >= n1 + 2) ? 32'(c1 & 4'hE) : 32'(c1));
        end
        wr(T0, 32'h0);
        wr(T1, 32'h0);

        // reset mid-count with an interrupt pending
        wr(OUTA, 32'hCAFE_F00D);
        wr(T0 + 4, 32'd1);
        wr(T1 + 4, 32'd10);
        wr(T0, 32'h9); e0 = ed;
        wr(T1, 32'h9);
        repeat (4) tick();
        chk("prerst_hwint", hw(), 32'h1);
        rd(T1 + 8, rv); chk("prerst_t1count", rv, 32'd8);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_hwint", hw(), 32'h0);
        chk("rst_devout", dev_out, 32'h0);
        rd(T0, rv); chk("rst_t0ctrl", rv, 32'h0);
        rd(T1, rv); chk("rst_t1ctrl", rv, 32'h0);
        rd(T1 + 8, rv); chk("rst_t1count", rv, 32'h0);
        rd(T0 + 4, rv); chk("rst_t0preset", rv, 32'h0);
        tick();
        rst = 1'b1;
        repeat (12) tick();
        chk("postrst_hwint", hw(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
